// File: rtl/ysyx_23060208_lsu_pkg.sv
// rtl/ysyx_23060208_lsu_pkg.sv - shared types and encodings for the load/store unit
package ysyx_23060208_lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_AR,
      ST_RD_R,
      ST_WR_AW_W,
      ST_WR_B,
      ST_RESP
   } state_t;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_MIS = 2'b01;
   localparam logic [1:0] ERR_BUS = 2'b10;

   // Natural alignment: address must be a multiple of the access size.
   function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
      case (size)
         SIZE_B:  return 1'b0;
         SIZE_H:  return addr_lo[0];
         SIZE_W:  return addr_lo[1:0] != 2'b00;
         default: return addr_lo != 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_23060208_lsu_align.sv
// rtl/ysyx_23060208_lsu_align.sv - byte-lane strobe, store shift and load extract/extend
module ysyx_23060208_lsu_align #(
   parameter int DATA_WIDTH = 32,
   parameter int STRB       = DATA_WIDTH / 8,
   parameter int OFF        = $clog2(STRB)
) (
   input  logic [1:0]            size,
   input  logic                  is_unsigned,
   input  logic [OFF-1:0]        offset,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [STRB-1:0]       wstrb,
   output logic [DATA_WIDTH-1:0] wdata_sh,
   output logic [DATA_WIDTH-1:0] rdata_ext
);
   import ysyx_23060208_lsu_pkg::*;

   logic [7:0]            base;
   logic [15:0]           strb16;
   logic [OFF+2:0]        sh;
   logic [DATA_WIDTH-1:0] raw;
   logic [63:0]           raw64;
   logic [63:0]           ext64;
   logic                  unused_hi;

   always_comb begin
      base = 8'hFF;
      case (size)
         SIZE_B:  base = 8'h01;
         SIZE_H:  base = 8'h03;
         SIZE_W:  base = 8'h0F;
         default: base = 8'hFF;
      endcase
      strb16   = {8'h00, base} << offset;
      wstrb    = strb16[STRB-1:0];
      sh       = {offset, 3'b000};
      wdata_sh = wdata << sh;
      raw      = rdata >> sh;
      raw64    = 64'(raw);
      // Sign bit of the selected width is replicated unless zero-extension is asked for.
      case (size)
         SIZE_B:  ext64 = {{56{~is_unsigned & raw64[7]}},  raw64[7:0]};
         SIZE_H:  ext64 = {{48{~is_unsigned & raw64[15]}}, raw64[15:0]};
         SIZE_W:  ext64 = {{32{~is_unsigned & raw64[31]}}, raw64[31:0]};
         default: ext64 = raw64;
      endcase
      rdata_ext = ext64[DATA_WIDTH-1:0];
   end

   assign unused_hi = ^{strb16, ext64};

endmodule

// File: rtl/ysyx_23060208_lsu.sv
// rtl/ysyx_23060208_lsu.sv - single-outstanding load/store unit, AXI4-Lite master
module ysyx_23060208_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_store,
   input  logic [1:0]              req_size,
   input  logic                    req_unsigned,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic [1:0]              resp_err,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready
);
   import ysyx_23060208_lsu_pkg::*;

   localparam int STRB     = DATA_WIDTH / 8;
   localparam int OFF      = $clog2(STRB);
   localparam bit NO_DWORD = (DATA_WIDTH < 64);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            err_q;
   logic                  aw_done_q, w_done_q;
   logic                  req_bad;
   logic [STRB-1:0]       strb_al;
   logic [DATA_WIDTH-1:0] wdata_al;
   logic [DATA_WIDTH-1:0] rdata_ext;
   logic                  unused_resp;

   assign req_bad     = misaligned(req_addr[2:0], req_size) || (NO_DWORD && req_size == SIZE_D);
   assign unused_resp = ^{bresp[0], rresp[0]};

   ysyx_23060208_lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .size        (size_q),
      .is_unsigned (uns_q),
      .offset      (addr_q[OFF-1:0]),
      .wdata       (wdata_q),
      .rdata       (rdata),
      .wstrb       (strb_al),
      .wdata_sh    (wdata_al),
      .rdata_ext   (rdata_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         size_q    <= SIZE_B;
         uns_q     <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= ERR_OK;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && req_valid) begin
            addr_q    <= req_addr;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            rdata_q   <= '0;
            err_q     <= req_bad ? ERR_MIS : ERR_OK;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end
         if (state_q == ST_WR_AW_W) begin
            if (awready) aw_done_q <= 1'b1;
            if (wready)  w_done_q  <= 1'b1;
         end
         if (state_q == ST_WR_B && bvalid) begin
            err_q <= bresp[1] ? ERR_BUS : ERR_OK;
         end
         if (state_q == ST_RD_R && rvalid) begin
            err_q   <= rresp[1] ? ERR_BUS : ERR_OK;
            rdata_q <= rresp[1] ? '0 : rdata_ext;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      resp_valid = 1'b0;
      wdata      = '0;
      wstrb      = '0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = req_bad ? ST_RESP : (req_store ? ST_WR_AW_W : ST_RD_AR);
            end
         end
         ST_RD_AR: begin
            arvalid = 1'b1;
            if (arready) state_d = ST_RD_R;
         end
         ST_RD_R: begin
            rready = 1'b1;
            if (rvalid) state_d = ST_RESP;
         end
         ST_WR_AW_W: begin
            // AW and W retire independently; either may complete first or both together.
            awvalid = ~aw_done_q;
            wvalid  = ~w_done_q;
            wdata   = wdata_al;
            wstrb   = strb_al;
            if ((aw_done_q || awready) && (w_done_q || wready)) state_d = ST_WR_B;
         end
         ST_WR_B: begin
            bready = 1'b1;
            if (bvalid) state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign awaddr     = addr_q;
   assign araddr     = addr_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// tb/tb_ysyx_23060208_lsu.sv - self-checking bench for ysyx_23060208_lsu (32- and 64-bit builds)
module tb_ysyx_23060208_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_store = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [31:0] awaddr, araddr, wdata;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = 2'b00, rresp = 2'b00;
   logic [31:0] rdata = '0;

   logic        q_req_valid = 1'b0, q_req_store = 1'b0, q_req_unsigned = 1'b0, q_resp_ready = 1'b0;
   logic [1:0]  q_req_size = 2'd0;
   logic [31:0] q_req_addr = '0;
   logic [63:0] q_req_wdata = '0, q_rdata = '0;
   logic        q_req_ready, q_resp_valid, q_awvalid, q_wvalid, q_bready, q_arvalid, q_rready;
   logic [63:0] q_resp_rdata, q_wdata;
   logic [1:0]  q_resp_err;
   logic [31:0] q_awaddr, q_araddr;
   logic [7:0]  q_wstrb;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   ysyx_23060208_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   ysyx_23060208_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) u_dut64 (
      .clk(clk), .rst(rst),
      .req_valid(q_req_valid), .req_ready(q_req_ready), .req_store(q_req_store), .req_size(q_req_size),
      .req_unsigned(q_req_unsigned), .req_addr(q_req_addr), .req_wdata(q_req_wdata),
      .resp_valid(q_resp_valid), .resp_ready(q_resp_ready), .resp_rdata(q_resp_rdata), .resp_err(q_resp_err),
      .awaddr(q_awaddr), .awvalid(q_awvalid), .awready(1'b1),
      .wdata(q_wdata), .wstrb(q_wstrb), .wvalid(q_wvalid), .wready(1'b1),
      .bresp(2'b00), .bvalid(1'b1), .bready(q_bready),
      .araddr(q_araddr), .arvalid(q_arvalid), .arready(1'b1),
      .rdata(q_rdata), .rresp(2'b00), .rvalid(1'b1), .rready(q_rready)
   );

   // Slave for the 32-bit DUT: each ready/valid comes after a programmable number of waiting cycles.
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
   logic [31:0] s_rdata = '0;
   logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;

   always @(negedge clk) begin
      if (arvalid) begin arready <= (ar_c >= ar_dly); ar_c <= ar_c + 1; end
      else begin arready <= 1'b0; ar_c <= 0; end
      if (awvalid) begin awready <= (aw_c >= aw_dly); aw_c <= aw_c + 1; end
      else begin awready <= 1'b0; aw_c <= 0; end
      if (wvalid) begin wready <= (w_c >= w_dly); w_c <= w_c + 1; end
      else begin wready <= 1'b0; w_c <= 0; end
      if (rready) begin
         rvalid <= (r_c >= r_dly);
         rdata  <= (r_c >= r_dly) ? s_rdata : $urandom;
         rresp  <= s_rresp;
         r_c    <= r_c + 1;
      end else begin rvalid <= 1'b0; r_c <= 0; end
      if (bready) begin bvalid <= (b_c >= b_dly); bresp <= s_bresp; b_c <= b_c + 1; end
      else begin bvalid <= 1'b0; b_c <= 0; end
   end

   // Bus monitor: handshake payloads, valid-cycle counts and valid/payload stability.
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, aw_cyc = 0, w_cyc = 0, ar_cyc = 0, viol = 0;
   logic [31:0] hs_awaddr = '0, hs_wdata = '0, hs_araddr = '0;
   logic [3:0]  hs_wstrb = '0;
   logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_rst = 1'b1;
   logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
   logic [3:0]  p_wstrb = '0;

   always @(posedge clk) begin
      if (!rst && !p_rst) begin
         if (p_aw && !(awvalid && awaddr == p_awaddr)) viol <= viol + 1;
         if (p_w && !(wvalid && wdata == p_wdata && wstrb == p_wstrb)) viol <= viol + 1;
         if (p_ar && !(arvalid && araddr == p_araddr)) viol <= viol + 1;
      end
      if (awvalid) aw_cyc <= aw_cyc + 1;
      if (wvalid)  w_cyc  <= w_cyc + 1;
      if (arvalid) ar_cyc <= ar_cyc + 1;
      if (awvalid && awready) begin aw_cnt <= aw_cnt + 1; hs_awaddr <= awaddr; end
      if (wvalid && wready) begin w_cnt <= w_cnt + 1; hs_wdata <= wdata; hs_wstrb <= wstrb; end
      if (arvalid && arready) begin ar_cnt <= ar_cnt + 1; hs_araddr <= araddr; end
      p_aw <= awvalid && !awready; p_awaddr <= awaddr;
      p_w  <= wvalid && !wready;   p_wdata  <= wdata; p_wstrb <= wstrb;
      p_ar <= arvalid && !arready; p_araddr <= araddr;
      p_rst <= rst;
   end

   // Reference model computed from the lane rules with plain arithmetic.
   function automatic bit m_bad(logic [31:0] a, int sz, int dw);
      return ((a % (32'd1 << sz)) != 0) || (sz == 3 && dw == 32);
   endfunction

   function automatic logic [63:0] m_strb(int o, int sz);
      return ((64'd1 << (1 << sz)) - 64'd1) << o;
   endfunction

   function automatic logic [63:0] m_load(logic [63:0] rd, int o, int sz, bit un, int dw);
      logic [63:0] v, m;
      int nb;
      nb = 8 << sz;
      v  = rd >> (8 * o);
      if (nb < 64) begin
         m = (64'd1 << nb) - 64'd1;
         v = v & m;
         if (!un && v[nb-1]) v = v | ~m;
      end
      if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   // Runs one request on the 32-bit DUT; lat counts cycles after the accept edge (1 = next cycle).
   task automatic do_req(input bit st, input logic [1:0] sz, input bit un, input logic [31:0] a,
                         input logic [31:0] wd, input int rr_dly, input bit hold,
                         output int lat, output logic [31:0] rd, output logic [1:0] er, output bit ok);
      ok = 1'b1;
      lat = 0;
      req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         if (resp_valid) begin lat = n; break; end
         @(posedge clk); #1;
      end
      rd = resp_rdata;
      er = resp_err;
      if (lat == 0) begin ok = 1'b0; return; end
      for (int k = 0; k < rr_dly; k++) begin
         @(posedge clk); #1;
         if (!resp_valid || resp_rdata !== rd || resp_err !== er) ok = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if ({req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid} !== 7'b1000000) begin
         failures++; $display("FAIL reset_ctrl got=%b want=1000000",
                              {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid});
      end
      checks++;
      if (resp_err !== 2'b00 || resp_rdata !== 32'h0 || awaddr !== 32'h0 || araddr !== 32'h0 ||
          wdata !== 32'h0 || wstrb !== 4'h0) begin
         failures++; $display("FAIL reset_data err=%b rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h want all 0",
                              resp_err, resp_rdata, awaddr, araddr, wdata, wstrb);
      end
      checks++;
      if (q_req_ready !== 1'b1 || q_wstrb !== 8'h00 || q_resp_valid !== 1'b0) begin
         failures++; $display("FAIL reset_64 req_ready=%b wstrb=%h resp_valid=%b want 1/00/0",
                              q_req_ready, q_wstrb, q_resp_valid);
      end
   endtask

   task automatic test_load_word;
      int lat; logic [31:0] rd; logic [1:0] er; bit ok;
      ar_dly = 0; r_dly = 0; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (lat != 3) begin failures++; $display("FAIL lw_latency got=%0d want=3", lat); end
      checks++;
      if (rd !== 32'hDEAD_BEEF || er !== 2'b00) begin
         failures++; $display("FAIL lw_data got=%h/%b want=deadbeef/00", rd, er);
      end
      checks++;
      if (hs_araddr !== 32'h8000_0004) begin
         failures++; $display("FAIL lw_araddr got=%h want=80000004", hs_araddr);
      end
   endtask

   task automatic test_load_byte;
      int lat; logic [31:0] rd; logic [1:0] er; bit ok;
      s_rdata = 32'h8012_3456;
      do_req(1'b0, 2'd0, 1'b0, 32'h8000_0103, 32'h0, 1, 1'b0, lat, rd, er, ok);
      checks++;
      if (rd !== 32'hFFFF_FF80 || er !== 2'b00 || !ok) begin
         failures++; $display("FAIL lb got=%h/%b ok=%0d want=ffffff80/00", rd, er, ok);
      end
      do_req(1'b0, 2'd0, 1'b1, 32'h8000_0103, 32'h0, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (rd !== 32'h0000_0080 || er !== 2'b00) begin
         failures++; $display("FAIL lbu got=%h/%b want=00000080/00", rd, er);
      end
   endtask

   task automatic test_store;
      int lat, aw0, w0; logic [31:0] rd; logic [1:0] er; bit ok;
      aw_dly = 4; w_dly = 0; b_dly = 0; s_bresp = 2'b00;
      aw0 = aw_cyc; w0 = w_cyc;
      do_req(1'b1, 2'd1, 1'b0, 32'h8000_0202, 32'hABCD_1234, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (hs_wstrb !== 4'b1100 || hs_wdata[31:16] !== 16'h1234 || hs_awaddr !== 32'h8000_0202) begin
         failures++; $display("FAIL sh_lanes strb=%b wdata=%h awaddr=%h want=1100/1234xxxx/80000202",
                              hs_wstrb, hs_wdata, hs_awaddr);
      end
      checks++;
      if (aw_cyc - aw0 != 5 || w_cyc - w0 != 1) begin
         failures++; $display("FAIL sh_valid_cycles aw=%0d w=%0d want=5/1", aw_cyc - aw0, w_cyc - w0);
      end
      checks++;
      if (er !== 2'b00 || rd !== 32'h0) begin
         failures++; $display("FAIL sh_resp got=%h/%b want=0/00", rd, er);
      end
      aw_dly = 0;
      do_req(1'b1, 2'd2, 1'b0, 32'h8000_0300, 32'h5555_AAAA, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (lat != 3 || hs_wstrb !== 4'hF || hs_wdata !== 32'h5555_AAAA) begin
         failures++; $display("FAIL sw_min lat=%0d strb=%h wdata=%h want=3/f/5555aaaa", lat, hs_wstrb, hs_wdata);
      end
   endtask

   task automatic test_misaligned;
      int lat, ar0, aw0; logic [31:0] rd; logic [1:0] er; bit ok;
      ar0 = ar_cyc; aw0 = aw_cyc;
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (lat != 1 || er !== 2'b01 || rd !== 32'h0) begin
         failures++; $display("FAIL lw_mis lat=%0d err=%b rdata=%h want=1/01/0", lat, er, rd);
      end
      do_req(1'b1, 2'd3, 1'b0, 32'h8000_0008, 32'h1, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (lat != 1 || er !== 2'b01) begin
         failures++; $display("FAIL sd_on_32 lat=%0d err=%b want=1/01", lat, er);
      end
      checks++;
      if (ar_cyc != ar0 || aw_cyc != aw0) begin
         failures++; $display("FAIL mis_no_bus ar=%0d aw=%0d want=0/0", ar_cyc - ar0, aw_cyc - aw0);
      end
   endtask

   task automatic test_bus_error;
      int lat; logic [31:0] rd; logic [1:0] er; bit ok;
      s_bresp = 2'b10;
      do_req(1'b1, 2'd2, 1'b0, 32'h8000_0400, 32'h1234_5678, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (er !== 2'b10) begin failures++; $display("FAIL store_slverr got=%b want=10", er); end
      s_bresp = 2'b00; s_rresp = 2'b11; s_rdata = 32'hFFFF_FFFF;
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0404, 32'h0, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (er !== 2'b10 || rd !== 32'h0) begin
         failures++; $display("FAIL load_decerr got=%h/%b want=0/10", rd, er);
      end
      s_rresp = 2'b01; s_rdata = 32'h0000_8001;
      do_req(1'b0, 2'd1, 1'b0, 32'h8000_0408, 32'h0, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (er !== 2'b00 || rd !== 32'hFFFF_8001) begin
         failures++; $display("FAIL load_exokay got=%h/%b want=ffff8001/00", rd, er);
      end
      s_rresp = 2'b00;
   endtask

   task automatic test_reset_mid;
      int lat, n; logic [31:0] rd; logic [1:0] er; bit ok;
      r_dly = 30;
      req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8000_0010;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rready && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (rready !== 1'b1) begin failures++; $display("FAIL reach_rd_r rready=%b want=1", rready); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid} !== 7'b1000000 ||
          resp_err !== 2'b00 || resp_rdata !== 32'h0 || araddr !== 32'h0) begin
         failures++; $display("FAIL mid_reset ctrl=%b err=%b rdata=%h araddr=%h want=1000000/00/0/0",
                              {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid},
                              resp_err, resp_rdata, araddr);
      end
      r_dly = 0; s_rdata = 32'h0BAD_F00D;
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (lat != 3 || rd !== 32'h0BAD_F00D || er !== 2'b00) begin
         failures++; $display("FAIL after_reset lat=%0d rdata=%h err=%b want=3/0badf00d/00", lat, rd, er);
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic [31:0] rd; logic [1:0] er; bit ok;
      s_rdata = 32'h1357_9BDF;
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0500, 32'h0, 0, 1'b1, lat, rd, er, ok);
      checks++;
      if (req_ready !== 1'b1 || arvalid !== 1'b0) begin
         failures++; $display("FAIL no_accept_on_resp req_ready=%b arvalid=%b want=1/0", req_ready, arvalid);
      end
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0504, 32'h0, 0, 1'b0, lat, rd, er, ok);
      checks++;
      if (lat != 3 || rd !== 32'h1357_9BDF || hs_araddr !== 32'h8000_0504) begin
         failures++; $display("FAIL back_to_back lat=%0d rdata=%h araddr=%h want=3/13579bdf/80000504",
                              lat, rd, hs_araddr);
      end
   endtask

   task automatic test_random;
      int lat, sz, o, ar0, aw0, w0;
      bit st, un, ok, bad;
      logic [31:0] a, wd, rd, exp_rd, exp_wd;
      logic [63:0] tmp;
      logic [1:0] er, exp_er;
      for (int i = 0; i < 40; i++) begin
         st = 1'($urandom_range(0, 1)); un = 1'($urandom_range(0, 1)); sz = $urandom_range(0, 3);
         a = {16'h8000, 16'($urandom)};
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         wd = $urandom;
         ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 3);
         w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
         s_rdata = $urandom;
         s_rresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         s_bresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
         do_req(st, 2'(sz), un, a, wd, $urandom_range(0, 2), 1'b0, lat, rd, er, ok);
         o = a % 4;
         bad = m_bad(a, sz, 32);
         exp_er = bad ? 2'b01 : (st ? (s_bresp[1] ? 2'b10 : 2'b00) : (s_rresp[1] ? 2'b10 : 2'b00));
         tmp = m_load({32'h0, s_rdata}, o, sz, un, 32);
         exp_rd = (st || exp_er != 2'b00) ? 32'h0 : tmp[31:0];
         checks++;
         if (!ok || er !== exp_er || rd !== exp_rd) begin
            failures++; $display("FAIL rand_resp i=%0d st=%0d sz=%0d a=%h got=%h/%b want=%h/%b ok=%0d",
                                 i, st, sz, a, rd, er, exp_rd, exp_er, ok);
         end
         checks++;
         if (bad) begin
            if (ar_cnt != ar0 || aw_cnt != aw0 || w_cnt != w0) begin
               failures++; $display("FAIL rand_nobus i=%0d ar=%0d aw=%0d w=%0d want=0", i,
                                    ar_cnt - ar0, aw_cnt - aw0, w_cnt - w0);
            end
         end else if (st) begin
            tmp = m_strb(o, sz);
            exp_wd = wd << (8 * o);
            if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || hs_awaddr !== a || hs_wdata !== exp_wd ||
                hs_wstrb !== tmp[3:0]) begin
               failures++; $display("FAIL rand_store i=%0d awaddr=%h wdata=%h strb=%h want=%h/%h/%h",
                                    i, hs_awaddr, hs_wdata, hs_wstrb, a, exp_wd, tmp[3:0]);
            end
         end else begin
            if (ar_cnt - ar0 != 1 || hs_araddr !== a) begin
               failures++; $display("FAIL rand_load i=%0d araddr=%h n=%0d want=%h/1", i, hs_araddr,
                                    ar_cnt - ar0, a);
            end
         end
      end
      checks++;
      if (viol != 0) begin failures++; $display("FAIL axi_stability violations=%0d want=0", viol); end
   endtask

   task automatic test_dw64;
      int lat; logic [63:0] exp;
      q_req_store = 1'b1; q_req_size = 2'd3; q_req_unsigned = 1'b0; q_req_addr = 32'h8000_0100;
      q_req_wdata = 64'h1122_3344_5566_7788; q_req_valid = 1'b1;
      @(posedge clk); #1;
      q_req_valid = 1'b0;
      checks++;
      if (q_wvalid !== 1'b1 || q_wstrb !== 8'hFF || q_wdata !== 64'h1122_3344_5566_7788) begin
         failures++; $display("FAIL sd_lanes wvalid=%b strb=%h wdata=%h want=1/ff/1122334455667788",
                              q_wvalid, q_wstrb, q_wdata);
      end
      lat = 0;
      for (int n = 1; n <= 50; n++) begin
         if (q_resp_valid) begin lat = n; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (lat != 3 || q_resp_err !== 2'b00) begin
         failures++; $display("FAIL sd_resp lat=%0d err=%b want=3/00", lat, q_resp_err);
      end
      q_resp_ready = 1'b1; @(posedge clk); #1; q_resp_ready = 1'b0;
      q_rdata = 64'h8000_0000_0123_4567;
      q_req_store = 1'b0; q_req_size = 2'd2; q_req_addr = 32'h8000_0104; q_req_valid = 1'b1;
      @(posedge clk); #1;
      q_req_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 50; n++) begin
         if (q_resp_valid) begin lat = n; break; end
         @(posedge clk); #1;
      end
      exp = m_load(q_rdata, 4, 2, 1'b0, 64);
      checks++;
      if (lat == 0 || q_resp_rdata !== exp || q_resp_err !== 2'b00) begin
         failures++; $display("FAIL lw_64 lat=%0d rdata=%h err=%b want=%h/00", lat, q_resp_rdata, q_resp_err, exp);
      end
      q_resp_ready = 1'b1; @(posedge clk); #1; q_resp_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_load_word();
      test_load_byte();
      test_store();
      test_misaligned();
      test_bus_error();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_dw64();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
